// File: rtl/mul_appr_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// booth_ref is a 64-bit behavioural model valid for WIDTH <= 32.
package mul_appr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // bits = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    d.one = bits[1] ^ bits[0];
    d.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    d.neg = bits[2] & ~(bits[1] & bits[0]);
    return d;
  endfunction

  // Truncated-partial-product product; cols = 0 yields the exact product.
  function automatic longint booth_ref(input longint a, input longint b, input int width,
                                       input int shift, input int cols);
    longint acc;
    longint pp;
    int     d;
    int     pw;
    acc = 0;
    pw  = 2 * width;
    for (int i = 0; i < width / 2; i++) begin
      d = -2 * int'((b >>> (2 * i + 1)) & 1) + int'((b >>> (2 * i)) & 1);
      if (i > 0) d = d + int'((b >>> (2 * i - 1)) & 1);
      pp = (longint'(d) * a) <<< (2 * i);
      if (cols >= 64) pp = 0;
      else if (cols > 0) pp = pp & ~((longint'(1) << cols) - 1);
      acc = acc + pp;
    end
    if (pw < 64) acc = (acc <<< (64 - pw)) >>> (64 - pw);
    return acc >>> shift;
  endfunction

endpackage

// File: rtl/mul_appr_booth_seq_pp.sv
// Radix-4 Booth partial-product generator: decodes one digit, scales the
// sign-extended multiplicand, shifts it to its column and optionally truncates.
module booth_r4_pp
  import mul_appr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int APPR_COLS = 16,
  parameter int IDX_W     = 4
) (
  input  logic [2:0]         bits_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               appr_en_i,
  output logic [2*WIDTH-1:0] pp_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] LOW_MASK =
      (APPR_COLS == 0) ? '0 : ({PW{1'b1}} >> (PW - APPR_COLS));

  booth_digit_t  dig;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] mag;
  logic [PW-1:0] signed_pp;
  logic [PW-1:0] shifted;

  // -2 * (-2^(WIDTH-1)) = 2^WIDTH still fits because everything is 2*WIDTH wide.
  always_comb begin
    dig       = booth_decode(bits_i);
    a_ext     = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    mag       = '0;
    if (dig.one)      mag = a_ext;
    else if (dig.two) mag = a_ext << 1;
    signed_pp = dig.neg ? (~mag + 1'b1) : mag;
    shifted   = signed_pp << {idx_i, 1'b0};
    pp_o      = appr_en_i ? (shifted & ~LOW_MASK) : shifted;
  end

endmodule

// File: rtl/mul_appr_booth_seq.sv
// Iterative radix-4 Booth signed multiplier with per-operation approximate mode,
// valid/ready on both sides and an arithmetic output shift of SHIFT_WIDTH.
module mul_appr_booth_seq
  import mul_appr_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SHIFT_WIDTH = 8,
  parameter int APPR_COLS   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               appr_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int N     = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(N + 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]            acc_q, acc_d;
  logic signed [WIDTH-1:0]  a_q, a_d;
  logic signed [WIDTH-1:0]  b_q, b_d;
  logic                     appr_q, appr_d;
  logic [PW-1:0]            out_q, out_d;

  logic [WIDTH+2:0]         b_ext;
  logic [2:0]               digit_bits;
  logic [PW-1:0]            pp;

  // b[-1] = 0 on the right; extra sign bits keep the cnt == N select in range.
  assign b_ext      = {{2{b_q[WIDTH-1]}}, b_q, 1'b0};
  assign digit_bits = b_ext[{cnt_q, 1'b0} +: 3];

  booth_r4_pp #(
    .WIDTH    (WIDTH),
    .APPR_COLS(APPR_COLS),
    .IDX_W    (CNT_W)
  ) u_pp (
    .bits_i   (digit_bits),
    .a_i      (a_q),
    .idx_i    (cnt_q),
    .appr_en_i(appr_q),
    .pp_o     (pp)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    appr_d  = appr_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          appr_d  = appr_en;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Digits occupy cnt 0..N-1; cnt == N is the extra cycle that scales acc.
        if (cnt_q == CNT_W'(N)) begin
          out_d   = $signed(acc_q) >>> SHIFT_WIDTH;
          state_d = DONE;
        end else begin
          acc_d = acc_q + pp;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      appr_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      appr_q  <= appr_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;

  a_result_matches_ref : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == CALC && cnt_q == CNT_W'(N)) |=>
      (out_q == PW'(booth_ref(longint'(a_q), longint'(b_q), WIDTH, SHIFT_WIDTH,
                              appr_q ? APPR_COLS : 0)))
  );

endmodule

// File: tb/tb_mul_appr_booth_seq.sv
// Scoreboard bench: the driver pushes expected results at accept time and a
// monitor compares them whenever the DUT hands a result over.
module tb_mul_appr_booth_seq;

  localparam int WIDTH       = 16;
  localparam int SHIFT_WIDTH = 8;
  localparam int APPR_COLS   = 16;
  localparam int NUM_RANDOM  = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              appr_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*WIDTH-1:0] dout;
  logic              busy;

  int     checks = 0;
  int     failures = 0;
  longint exp_q[$];
  bit     rand_ready = 1'b0;

  mul_appr_booth_seq #(
    .WIDTH      (WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .APPR_COLS  (APPR_COLS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .appr_en  (appr_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact = plain product; approximate = sum over Booth digits
  // d_i = b[2i-1] + b[2i] - 2*b[2i+1] of d_i*a*4^i with the low columns floored away.
  function automatic longint model(input longint av, input longint bv, input bit appr);
    longint acc;
    longint pp;
    longint m;
    longint r;
    int     d;
    longint ub;
    if (!appr) return (av * bv) >>> SHIFT_WIDTH;
    ub  = bv & 64'hFFFF;
    m   = longint'(1) << APPR_COLS;
    acc = 0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      d = int'((ub >> (2 * i)) & 1) - 2 * int'((ub >> (2 * i + 1)) & 1);
      if (i > 0) d = d + int'((ub >> (2 * i - 1)) & 1);
      pp = longint'(d) * av * (longint'(1) << (2 * i));
      r  = pp % m;
      if (r < 0) r = r + m;
      acc = acc + (pp - r);
    end
    acc = longint'(int'(acc));
    return acc >>> SHIFT_WIDTH;
  endfunction

  // Monitor: a result is consumed on any clock edge where valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0d with empty scoreboard", $signed(dout));
        end else begin
          check("result", longint'($signed(dout)), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Presents operands, waits (bounded) for acceptance, pushes the expectation.
  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input bit ap, input longint expv);
    bit accepted;
    @(posedge clk);
    #1;
    a        = ia;
    b        = ib;
    appr_en  = ap;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("accept_timeout", longint'(in_ready), 1);
    else exp_q.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) return;
    end
    check("valid_timeout", longint'(out_valid), 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready && !out_valid) return;
    end
    check("idle_timeout", longint'(in_ready), 1);
  endtask

  initial begin
    int     lat;
    longint ea, eb, ex, ap_val;
    bit     ap;
    real    err, sum_err, sum_sq;
    int     n_appr, n_err;
    logic [WIDTH-1:0] ra, rb;

    void'($urandom(200));
    sum_err = 0.0;
    sum_sq  = 0.0;
    n_appr  = 0;
    n_err   = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_busy", longint'(busy), 0);
    check("reset_out", longint'(dout), 0);

    // Directed: latency and known products.
    out_ready = 1'b1;
    issue(16'd1000, -16'sd494, 1'b0, -1930);
    wait_valid(lat);
    check("latency", lat, 9);
    check("busy_in_done", longint'(busy), 1);
    wait_idle();

    issue(16'd32767, 16'd3, 1'b1, 0);
    wait_idle();
    issue(16'd32767, 16'd3, 1'b0, 383);
    wait_idle();
    issue(16'h8000, 16'h8000, 1'b0, 4194304);
    wait_idle();
    issue(16'h8000, 16'h8000, 1'b1, 4194304);
    wait_idle();

    // Back-pressure: result held for 5 cycles, new operands ignored.
    out_ready = 1'b0;
    issue(16'd123, -16'sd456, 1'b0, -220);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'(i % 2 == 0);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(negedge clk);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out", longint'($signed(dout)), -220);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", longint'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_extra_op", longint'(busy), 0);

    // Reset during CALC abandons the operation.
    issue(16'd5, 16'd5, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_busy", longint'(busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", longint'(in_ready), 1);
    check("abort_out_valid_after", longint'(out_valid), 0);
    issue(-16'sd7, 16'd9, 1'b0, -1);
    wait_idle();

    // Random traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < NUM_RANDOM; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) ra = (ra[0]) ? 16'h8000 : 16'h7FFF;
      if ($urandom_range(0, 7) == 0) rb = (rb[0]) ? 16'h8000 : 16'hFFFF;
      ap = 1'($urandom_range(0, 1));
      ea = longint'($signed(ra));
      eb = longint'($signed(rb));
      ap_val = model(ea, eb, ap);
      if (ap) begin
        ex  = model(ea, eb, 1'b0);
        err = real'(ap_val - ex);
        sum_err += err;
        sum_sq  += err * err;
        n_appr++;
        if (ap_val != ex) n_err++;
      end
      issue(ra, rb, ap, ap_val);
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    rand_ready = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);

    if (n_appr > 0)
      $display("approx_stats ops=%0d mean_err=%f std_err=%f err_rate=%f", n_appr,
               sum_err / n_appr,
               $sqrt(sum_sq / n_appr - (sum_err / n_appr) * (sum_err / n_appr)),
               real'(n_err) / n_appr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
